// File: rtl/banner_pkg.sv
// Shared types and constants for the scrolling 7-segment banner controller.
package banner_pkg;

    localparam int POS_W  = 5;
    localparam int ADDR_W = 4;
    localparam int DATA_W = 5;

    localparam logic [DATA_W-1:0] BLANK = 5'h10;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HOLD
    } state_t;

endpackage

// File: rtl/msg_buffer.sv
// Message register file: one write port, combinational read port, entries reset to BLANK.
module msg_buffer
    import banner_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= BLANK;
            end
        end else if (we_i) begin
            mem_q[waddr_i[AW-1:0]] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i[AW-1:0]];

endmodule

// File: rtl/banner_sequencer.sv
// Scrolls a programmable message across the digit window and scans one digit per display tick.
module banner_sequencer
    import banner_pkg::*;
#(
    parameter int MSG_DEPTH = 16,
    parameter int DIGITS    = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      tick_display,
    input  logic                      tick_banner,
    input  logic                      wr_valid,
    output logic                      wr_ready,
    input  logic [ADDR_W-1:0]         wr_addr,
    input  logic [DATA_W-1:0]         wr_data,
    input  logic [POS_W-1:0]          cfg_len,
    input  logic                      start,
    input  logic                      stop,
    input  logic                      hold,
    output logic                      busy,
    output logic                      wrap,
    output logic [$clog2(DIGITS)-1:0] digit_sel,
    output logic [3:0]                value,
    output logic                      off_display
);

    localparam int SEL_W = $clog2(DIGITS);

    state_t            state_q;
    logic [POS_W-1:0]  pos_q;
    logic [POS_W-1:0]  len_q;
    logic [SEL_W-1:0]  sel_q;
    logic [3:0]        value_q;
    logic              off_q;
    logic              wrap_q;

    logic              running;
    logic              start_ok;
    logic              advance;
    logic              last_pos;
    logic [POS_W-1:0]  n_pos;
    logic [SEL_W-1:0]  sel_d;
    logic [POS_W:0]    sum_v;
    logic [POS_W:0]    vidx;
    logic              leading_blank;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;

    assign running  = (state_q != IDLE);
    assign start_ok = start && !stop && (cfg_len != '0) && (cfg_len <= POS_W'(MSG_DEPTH));
    assign advance  = running && tick_banner && !hold && !stop;
    assign n_pos    = len_q + POS_W'(DIGITS);
    assign last_pos = (pos_q == n_pos - POS_W'(1));

    // The display register shows the digit it is about to select, so index with sel_d.
    assign sel_d         = sel_q + SEL_W'(1);
    assign sum_v         = {1'b0, pos_q} + {{(POS_W + 1 - SEL_W){1'b0}}, sel_d};
    assign vidx          = (sum_v >= {1'b0, n_pos}) ? sum_v - {1'b0, n_pos} : sum_v;
    assign leading_blank = (vidx < (POS_W + 1)'(DIGITS));
    assign rd_addr       = ADDR_W'(vidx - (POS_W + 1)'(DIGITS));

    msg_buffer #(
        .DEPTH (MSG_DEPTH)
    ) u_buf (
        .clk     (clk),
        .rst_n   (rst),
        .we_i    (wr_valid && !running),
        .waddr_i (wr_addr),
        .wdata_i (wr_data),
        .raddr_i (rd_addr),
        .rdata_o (rd_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            pos_q   <= '0;
            len_q   <= '0;
            wrap_q  <= 1'b0;
        end else begin
            wrap_q <= advance && last_pos;
            if (advance) begin
                pos_q <= last_pos ? '0 : pos_q + POS_W'(1);
            end
            case (state_q)
                IDLE: begin
                    if (start_ok) begin
                        state_q <= RUN;
                        len_q   <= cfg_len;
                        pos_q   <= '0;
                    end
                end
                RUN: begin
                    if (stop) begin
                        state_q <= IDLE;
                        pos_q   <= '0;
                    end else if (hold) begin
                        state_q <= HOLD;
                    end
                end
                HOLD: begin
                    if (stop) begin
                        state_q <= IDLE;
                        pos_q   <= '0;
                    end else if (!hold) begin
                        state_q <= RUN;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sel_q   <= '0;
            value_q <= '0;
            off_q   <= 1'b1;
        end else if (tick_display) begin
            sel_q <= sel_d;
            if (!running || leading_blank) begin
                value_q <= '0;
                off_q   <= 1'b1;
            end else begin
                value_q <= rd_data[3:0];
                off_q   <= rd_data[4];
            end
        end
    end

    assign wr_ready    = !running;
    assign busy        = running;
    assign wrap        = wrap_q;
    assign digit_sel   = sel_q;
    assign value       = value_q;
    assign off_display = off_q;

endmodule

// File: doc/banner_sequencer.md
# banner_sequencer

Scroll controller for the 4-digit 7-segment banner. It owns a 16-entry message buffer that the host writes through a valid/ready port. It advances a scrolling window on each `tick_banner` and scans the window one digit per `tick_display`. It feeds the existing 7-segment driver with `value`, `digit_sel` and `off_display`, replacing the fixed counter arithmetic in the banner top level with a programmable message.

## Interface
Parameters:
- `MSG_DEPTH`, 16: message buffer entries; power of two, at most 16.
- `DIGITS`, 4: physical digits; power of two.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-low reset.
- `tick_display` in 1: one-cycle digit-scan strobe from `clk_div`.
- `tick_banner` in 1: one-cycle scroll strobe from `clk_div`.
- `wr_valid` in 1: write request.
- `wr_ready` out 1: buffer accepts a write.
- `wr_addr` in 4: entry index.
- `wr_data` in 5: bit 4 is the blank flag; bits 3:0 are the hex nibble.
- `cfg_len` in 5: message length, 1..16; sampled on an accepted `start`.
- `start` in 1: begin scrolling (level or pulse).
- `stop` in 1: return to IDLE.
- `hold` in 1: freeze scrolling while high; the scan continues.
- `busy` out 1: state is not IDLE.
- `wrap` out 1: one-cycle pulse when the window returns to position 0.
- `digit_sel` out 2: digit currently driven, 0 is leftmost.
- `value` out 4: nibble for the selected digit.
- `off_display` out 1: blank the selected digit.

## Operation
- Virtual sequence: `DIGITS` blank positions followed by `len` buffer entries, giving `N = len + DIGITS` positions. Index `v < DIGITS` is blank; otherwise the position holds `buf[v - DIGITS]`.
- Window position `pos` runs over 0..N-1. Digit `k` shows virtual index `(pos + k) mod N`, computed as a conditional subtract with no divider. The width is 5 bits and N is at most 20.
- An entry with `wr_data[4]` set drives `off_display = 1`.
- States:
  - IDLE: `wr_ready = 1` and a write occurs when `wr_valid` is high. `off_display = 1` and `pos = 0`.
  - IDLE -> RUN: `start` with `cfg_len` in 1..16 latches `len`. Any other `cfg_len` (0 or above 16) is ignored and the state stays IDLE.
  - RUN: each `tick_banner` advances `pos`. When `pos == N-1`, `pos` becomes 0 and `wrap` pulses.
  - RUN -> HOLD: `hold` high. HOLD -> RUN: `hold` low. In HOLD `pos` is frozen and the scan continues.
  - RUN or HOLD -> IDLE: `stop`.
- `wr_ready = 0` outside IDLE. A write presented there stalls and is not dropped.
- The scan counter `digit_sel` increments modulo `DIGITS` on every `tick_display` in all states. In IDLE it runs but the display is blanked.

## Timing
- Reset values: state IDLE, `pos = 0`, `digit_sel = 0`, `value = 0`, `off_display = 1`, `wrap = 0`, `busy = 0`. All buffer entries reset to blank (5'h10).
- Writes: an accepted write on cycle t is readable on cycle t+1.
- Display outputs are registered. `digit_sel`, `value` and `off_display` update together one cycle after `tick_display` and are stable between ticks.
- A `pos` change becomes visible at the next `tick_display` update, not immediately.
- `wrap` is asserted on the cycle after the `tick_banner` that wraps `pos`.
- `start` and `stop` in the same cycle: `stop` wins.
- `stop` and `tick_banner` in the same cycle: go to IDLE and `pos` becomes 0.
- `hold` and `tick_banner` in the same cycle: there is no advance.
- `tick_display` and `tick_banner` in the same cycle: both act. The registered digit uses the pre-advance `pos`.
- Assertion of `rst` mid-scroll forces the reset values asynchronously. Deassertion is synchronised externally.
- `cfg_len` changes during RUN are ignored until the next `start`.

## Structure
- Shared package `banner_pkg`:
  - `BLANK = 5'h10`.
  - State enum: IDLE, RUN, HOLD.
  - Widths: `POS_W = 5`, `ADDR_W = 4`, `DATA_W = 5`.
- Sub-module `msg_buffer`: a `MSG_DEPTH` x 5 register file with an asynchronous-reset-to-BLANK write port and a combinational read port.
- The top holds the FSM, `pos`/scan counters, index arithmetic and output registers. Target size is about 200 lines of RTL.

## Test plan
- Reset then write: write entries 0..3 = 1,2,3,4, `start` with `cfg_len = 4`. Over 8 banner ticks the digits show blanks then 1234 scrolling in. `wrap` pulses on the 8th tick and `pos` returns to 0.
- Flow control: `wr_valid` during RUN gives `wr_ready = 0` and the buffer is unchanged. After `stop` the pending write lands on the next cycle.
- Length guard: `start` with `cfg_len = 0` leaves the state IDLE and `busy = 0`. `cfg_len = 16` gives a wrap every 20 ticks.
- Hold: assert `hold` at `pos = 3` for 5 banner ticks and `pos` stays 3 while the scan continues. Release `hold` and the next tick moves `pos` to 4.
- Simultaneous events: `start` and `stop` together keep IDLE. `stop` with `tick_banner` gives `pos = 0`. Ticks together show the pre-advance digit.
- Async reset mid-RUN at `pos = 5`: outputs go immediately to the reset values and every entry reads back as BLANK.
